// File: rtl/cdb_pkg.sv
// cdb_pkg: shared types and constants for the common-data-bus arbiter.
//   cdb_pkt_t   broadcast payload (result value, rename/ROB tags, PC, branch fields)
//   CH_W        width of a channel index for the default channel count
//   CH_ALU..CH_SQ  channel IDs of the default producer set (0 = highest fixed priority)
package cdb_pkg;

    localparam int unsigned CDB_NUM_CH = 5;
    localparam int unsigned CDB_DEPTH  = 4;
    localparam int unsigned CDB_LANES  = 2;

    localparam int unsigned CH_W      = $clog2(CDB_NUM_CH);
    localparam int unsigned XLEN      = 32;
    localparam int unsigned PRF_IDX_W = 6;
    localparam int unsigned ROB_IDX_W = 5;

    localparam logic [CH_W-1:0] CH_ALU    = CH_W'(0);
    localparam logic [CH_W-1:0] CH_MUL    = CH_W'(1);
    localparam logic [CH_W-1:0] CH_BR     = CH_W'(2);
    localparam logic [CH_W-1:0] CH_DCACHE = CH_W'(3);
    localparam logic [CH_W-1:0] CH_SQ     = CH_W'(4);

    typedef struct packed {
        logic [XLEN-1:0]      value;
        logic [PRF_IDX_W-1:0] prf_idx;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [XLEN-1:0]      pc;
        logic                 br_direction;
        logic [XLEN-1:0]      br_target_pc;
        logic                 mis_pred;
        logic                 local_pred_dir;
        logic                 global_pred_dir;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_chan_fifo.sv
// cdb_chan_fifo: per-channel result queue feeding the CDB arbiter.
//   clock, reset   clock and synchronous active-high reset
//   flush_i        squash all entries (pointers and count clear at the edge)
//   push_i         enqueue push_pkt_i (ignored when full or flushing)
//   pop_i          dequeue the head entry (ignored when empty or flushing)
//   head_pkt_o     oldest entry; meaningless while empty_o
//   full_o/empty_o occupancy flags derived from the registered count
module cdb_chan_fifo
    import cdb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     flush_i,
    input  logic     push_i,
    input  cdb_pkt_t push_pkt_i,
    input  logic     pop_i,
    output cdb_pkt_t head_pkt_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    cdb_pkt_t         mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign head_pkt_o = mem_q[head_q];
    assign do_push    = push_i && !full_o && !flush_i;
    assign do_pop     = pop_i && !empty_o && !flush_i;

    // Next-state for pointers and count; wrap by compare so DEPTH need not be a power of 2.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
            end
            if (do_pop) begin
                head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; contents need no reset since empty entries are never broadcast.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[tail_q] <= push_pkt_i;
        end
    end

endmodule

// File: rtl/cdb_multi_lane_arbiter.sv
// cdb_multi_lane_arbiter: queues results from NUM_CH producers and broadcasts up to
// LANES of them per cycle on the common data bus.
//   clock, reset  clock and synchronous active-high reset
//   flush         mispredict squash: blocks broadcast and pushes, clears every queue
//   in_valid/in_pkt/in_ready   per-channel producer handshake
//   out_valid/out_pkt/out_src  per-lane broadcast (payload and source '0 when idle)
//   busy          any channel queue non-empty
// Build option: define CDB_RR_ARB_EN for rotating priority starting at rr_ptr;
// otherwise channel 0 always has the highest priority.
module cdb_multi_lane_arbiter
    import cdb_pkg::*;
#(
    parameter  int unsigned NUM_CH = CDB_NUM_CH,
    parameter  int unsigned DEPTH  = CDB_DEPTH,
    parameter  int unsigned LANES  = CDB_LANES,
    localparam int unsigned SRC_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic     [NUM_CH-1:0]        in_valid,
    input  cdb_pkt_t [NUM_CH-1:0]        in_pkt,
    output logic     [NUM_CH-1:0]        in_ready,
    output logic     [LANES-1:0]         out_valid,
    output cdb_pkt_t [LANES-1:0]         out_pkt,
    output logic     [LANES-1:0][SRC_W-1:0] out_src,
    output logic                         busy
);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] avail;
    cdb_pkt_t          head_pkt [NUM_CH];
    logic [SRC_W-1:0]  sel;
    logic [SRC_W-1:0]  idx;
    logic              found;

`ifdef CDB_RR_ARB_EN
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]  last_src;
    logic              any_grant;
    int unsigned       rr_sum;
`endif

    // Readiness depends only on registered fullness and flush, never on this cycle's pop.
    assign in_ready = ~full & ~{NUM_CH{flush}};
    assign push     = in_valid & in_ready;
    assign busy     = |(~empty);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cdb_chan_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .flush_i    (flush),
            .push_i     (push[c]),
            .push_pkt_i (in_pkt[c]),
            .pop_i      (grant[c]),
            .head_pkt_o (head_pkt[c]),
            .full_o     (full[c]),
            .empty_o    (empty[c])
        );
    end

    // Lane fill: each lane takes the first remaining requester in priority order,
    // then masks it out so no channel wins twice in one cycle.
    always_comb begin
        avail     = ~empty & ~{NUM_CH{flush}};
        grant     = '0;
        out_valid = '0;
        out_pkt   = '0;
        out_src   = '0;
        sel       = '0;
        idx       = '0;
        found     = 1'b0;
`ifdef CDB_RR_ARB_EN
        last_src  = '0;
        any_grant = 1'b0;
        rr_sum    = 0;
`endif
        for (int l = 0; l < LANES; l++) begin
            found = 1'b0;
            sel   = '0;
            for (int k = 0; k < NUM_CH; k++) begin
`ifdef CDB_RR_ARB_EN
                rr_sum = int'(rr_ptr_q) + k;
                if (rr_sum >= NUM_CH) begin
                    rr_sum = rr_sum - NUM_CH;
                end
                idx = SRC_W'(rr_sum);
`else
                idx = SRC_W'(k);
`endif
                if (!found && avail[idx]) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
            if (found) begin
                avail[sel]   = 1'b0;
                grant[sel]   = 1'b1;
                out_valid[l] = 1'b1;
                out_src[l]   = sel;
                out_pkt[l]   = head_pkt[sel];
`ifdef CDB_RR_ARB_EN
                last_src     = sel;
                any_grant    = 1'b1;
`endif
            end
        end
    end

`ifdef CDB_RR_ARB_EN
    // Rotate past the last lane granted; hold when nothing was broadcast (including flush).
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            rr_ptr_d = (last_src == SRC_W'(NUM_CH - 1)) ? '0 : last_src + SRC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_multi_lane_arbiter.sv
// Directed self-checking bench for cdb_multi_lane_arbiter (NUM_CH=5, DEPTH=4, LANES=2).
module tb_cdb_multi_lane_arbiter;
    import cdb_pkg::*;

    localparam int unsigned NCH = 5;
    localparam int unsigned LN  = 2;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    flush;
    logic     [NCH-1:0]      in_valid;
    cdb_pkt_t [NCH-1:0]      in_pkt;
    logic     [NCH-1:0]      in_ready;
    logic     [LN-1:0]       out_valid;
    cdb_pkt_t [LN-1:0]       out_pkt;
    logic     [LN-1:0][2:0]  out_src;
    logic                    busy;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_multi_lane_arbiter #(
        .NUM_CH (NCH),
        .DEPTH  (4),
        .LANES  (LN)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pkt    (in_pkt),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pkt   (out_pkt),
        .out_src   (out_src),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Producer protocol: presenting a result the FIFO cannot take drops it.
    always @(negedge clock) begin
        if (!reset && ((in_valid & ~in_ready & ~{NCH{flush}}) != '0)) begin
            n_fail++;
            $display("FAIL protocol: in_valid=%b in_ready=%b", in_valid, in_ready);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic cdb_pkt_t mk(input int rob, input int val);
        cdb_pkt_t p;
        p         = '0;
        p.value   = XLEN'(val);
        p.rob_idx = ROB_IDX_W'(rob);
        p.prf_idx = PRF_IDX_W'(rob + 32);
        p.pc      = XLEN'(32'h1000 + rob * 4);
        return p;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        in_pkt   = '0;
        flush    = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++; if (in_ready !== 5'b11111) begin n_fail++; $display("FAIL reset_in_ready: got %b want 11111", in_ready); end
        n_tests++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid: got %b want 00", out_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (out_pkt !== '0) begin n_fail++; $display("FAIL reset_out_pkt: got %h want 0", out_pkt); end
        n_tests++; if (out_src !== '0) begin n_fail++; $display("FAIL reset_out_src: got %h want 0", out_src); end
    endtask

    task automatic test_two_lane();
        apply_reset();
        in_valid  = 5'b10001;
        in_pkt[0] = mk(3, 32'hA3);
        in_pkt[4] = mk(7, 32'hB7);
        settle();
        n_tests++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL two_lane_no_bypass: got %b want 00", out_valid); end
        tick();
        idle_inputs();
        settle();
        n_tests++; if (out_valid !== 2'b11) begin n_fail++; $display("FAIL two_lane_valid: got %b want 11", out_valid); end
        n_tests++; if (out_src[0] !== 3'd0 || out_pkt[0].rob_idx !== 5'd3) begin n_fail++; $display("FAIL two_lane_lane0: got src %0d rob %0d want src 0 rob 3", out_src[0], out_pkt[0].rob_idx); end
        n_tests++; if (out_src[1] !== 3'd4 || out_pkt[1].rob_idx !== 5'd7) begin n_fail++; $display("FAIL two_lane_lane1: got src %0d rob %0d want src 4 rob 7", out_src[1], out_pkt[1].rob_idx); end
        n_tests++; if (out_pkt[1] !== mk(7, 32'hB7)) begin n_fail++; $display("FAIL two_lane_payload: got %h want %h", out_pkt[1], mk(7, 32'hB7)); end
        tick();
        n_tests++; if (out_valid !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL two_lane_idle: got valid %b busy %b want 00 0", out_valid, busy); end
    endtask

    // Channels 0 and 1 stream continuously and hold both lanes while channel 4 fills.
    task automatic test_fill_wrap();
        apply_reset();
        in_valid  = 5'b00011;
        in_pkt[0] = mk(10, 1);
        in_pkt[1] = mk(11, 2);
        tick();
        for (int k = 1; k <= 4; k++) begin
            in_valid  = 5'b10011;
            in_pkt[4] = mk(20 + k, 100 + k);
            settle();
            n_tests++; if (in_ready[4] !== 1'b1) begin n_fail++; $display("FAIL fill_ready_before_%0d: got %b want 1", k, in_ready[4]); end
            n_tests++; if (out_valid !== 2'b11 || out_src[0] !== 3'd0 || out_src[1] !== 3'd1) begin n_fail++; $display("FAIL fill_blocked_%0d: got valid %b src %0d,%0d want 11 src 0,1", k, out_valid, out_src[0], out_src[1]); end
            tick();
        end
        idle_inputs();
        settle();
        n_tests++; if (in_ready[4] !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b want 0", in_ready[4]); end
        tick();
        for (int j = 1; j <= 4; j++) begin
            settle();
            n_tests++; if (out_valid !== 2'b01 || out_src[0] !== 3'd4 || out_pkt[0].rob_idx !== 5'(20 + j)) begin n_fail++; $display("FAIL drain_%0d: got valid %b src %0d rob %0d want 01 src 4 rob %0d", j, out_valid, out_src[0], out_pkt[0].rob_idx, 20 + j); end
            if (j == 1) begin
                n_tests++; if (in_ready[4] !== 1'b0) begin n_fail++; $display("FAIL full_while_pop: got %b want 0", in_ready[4]); end
            end
            tick();
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_busy: got %b want 0", busy); end
        in_valid  = 5'b10000;
        in_pkt[4] = mk(30, 300);
        tick();
        idle_inputs();
        settle();
        n_tests++; if (out_valid !== 2'b01 || out_pkt[0] !== mk(30, 300)) begin n_fail++; $display("FAIL wrap_push: got valid %b pkt %h want 01 %h", out_valid, out_pkt[0], mk(30, 300)); end
        tick();
    endtask

    task automatic test_priority_sweep();
        logic [1:0] exp_v  [4];
        logic [2:0] exp_s0 [4];
        logic [2:0] exp_s1 [4];
`ifdef CDB_RR_ARB_EN
        exp_v  = '{2'b11, 2'b11, 2'b11, 2'b11};
        exp_s0 = '{3'd0, 3'd2, 3'd4, 3'd1};
        exp_s1 = '{3'd1, 3'd3, 3'd0, 3'd2};
`else
        exp_v  = '{2'b11, 2'b11, 2'b01, 2'b00};
        exp_s0 = '{3'd0, 3'd2, 3'd4, 3'd0};
        exp_s1 = '{3'd1, 3'd3, 3'd0, 3'd0};
`endif
        apply_reset();
        in_valid = 5'b11111;
        for (int i = 0; i < 5; i++) in_pkt[i] = mk(i, 50 + i);
        settle();
        n_tests++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL sweep_no_bypass: got %b want 00", out_valid); end
        tick();
`ifdef CDB_RR_ARB_EN
        for (int i = 0; i < 5; i++) in_pkt[i] = mk(8 + i, 60 + i);
`else
        idle_inputs();
`endif
        for (int j = 0; j < 4; j++) begin
            settle();
            n_tests++; if (out_valid !== exp_v[j] || out_src[0] !== exp_s0[j] || out_src[1] !== exp_s1[j]) begin n_fail++; $display("FAIL sweep_step%0d: got valid %b src %0d,%0d want %b src %0d,%0d", j, out_valid, out_src[0], out_src[1], exp_v[j], exp_s0[j], exp_s1[j]); end
            idle_inputs();
            tick();
        end
    endtask

    // Channels 3 and 4 accumulate 3 entries behind streaming channels 0 and 1, then flush.
    task automatic test_flush();
        apply_reset();
        in_valid  = 5'b00011;
        in_pkt[0] = mk(1, 1);
        in_pkt[1] = mk(2, 2);
        tick();
        for (int k = 0; k < 3; k++) begin
            in_valid  = 5'b11011;
            in_pkt[3] = mk(12 + k, 3);
            in_pkt[4] = mk(16 + k, 4);
            tick();
        end
        idle_inputs();
        flush     = 1'b1;
        in_valid  = 5'b00100;
        in_pkt[2] = mk(15, 5);
        settle();
        n_tests++; if (out_valid !== 2'b00 || out_pkt !== '0) begin n_fail++; $display("FAIL flush_out: got valid %b pkt %h want 00 0", out_valid, out_pkt); end
        n_tests++; if (in_ready !== 5'b00000) begin n_fail++; $display("FAIL flush_ready: got %b want 00000", in_ready); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b want 1", busy); end
        tick();
        idle_inputs();
        settle();
        n_tests++; if (busy !== 1'b0 || out_valid !== 2'b00) begin n_fail++; $display("FAIL flush_after: got busy %b valid %b want 0 00", busy, out_valid); end
        n_tests++; if (in_ready !== 5'b11111) begin n_fail++; $display("FAIL flush_after_ready: got %b want 11111", in_ready); end
        in_valid  = 5'b01000;
        in_pkt[3] = mk(9, 99);
        tick();
        idle_inputs();
        settle();
        n_tests++; if (out_valid !== 2'b01 || out_src[0] !== 3'd3 || out_pkt[0] !== mk(9, 99)) begin n_fail++; $display("FAIL post_flush_push: got valid %b src %0d pkt %h want 01 src 3 %h", out_valid, out_src[0], out_pkt[0], mk(9, 99)); end
        tick();
    endtask

    task automatic test_branch_fields();
        cdb_pkt_t br_p;
        cdb_pkt_t alu_p;
        apply_reset();
        alu_p = mk(2, 32'h11);
        br_p  = mk(4, 32'h55);
        br_p.br_direction = 1'b1;
        br_p.br_target_pc = 32'h100;
        br_p.mis_pred     = 1'b1;
        br_p.global_pred_dir = 1'b1;
        in_valid  = 5'b00101;
        in_pkt[0] = alu_p;
        in_pkt[2] = br_p;
        tick();
        idle_inputs();
        settle();
        n_tests++; if (out_src[1] !== 3'd2 || out_pkt[1].mis_pred !== 1'b1 || out_pkt[1].br_target_pc !== 32'h100) begin n_fail++; $display("FAIL branch_lane: got src %0d mis_pred %b target %h want 2 1 100", out_src[1], out_pkt[1].mis_pred, out_pkt[1].br_target_pc); end
        n_tests++; if (out_pkt[1] !== br_p) begin n_fail++; $display("FAIL branch_payload: got %h want %h", out_pkt[1], br_p); end
        n_tests++; if (out_src[0] !== 3'd0 || out_pkt[0].mis_pred !== 1'b0 || out_pkt[0].br_target_pc !== 32'h0 || out_pkt[0].br_direction !== 1'b0) begin n_fail++; $display("FAIL alu_br_zero: got src %0d mis_pred %b target %h dir %b want 0 0 0 0", out_src[0], out_pkt[0].mis_pred, out_pkt[0].br_target_pc, out_pkt[0].br_direction); end
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_two_lane();
`ifndef CDB_RR_ARB_EN
        test_fill_wrap();
`endif
        test_priority_sweep();
        test_flush();
        test_branch_fields();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
